// File: rtl/play_analyser_seq_uc.sv
// play_analyser_seq_uc: control unit for the play analyser.
// Buffers one pending request per player, grants them round-robin, then runs
// register -> compare -> send MSG_LEN report chars over the tx block -> pronto.
// Optional feature macro: TX_WATCHDOG_EN (abort to ERRO if pronto_tx never comes).
//
// Handshake: button_activation[i] is a fire-and-forget request pulse, held in
// pending until player i is granted; partida_tx is a one-cycle start per char
// and pronto_tx is its one-cycle completion, honoured only while waiting (AGUARDA).
module play_analyser_seq_uc #(
  parameter int N_PLAYERS      = 2,
  parameter int MSG_LEN        = 8,
  parameter int TIMEOUT_CYCLES = 50000,
  localparam int CW = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1,
  localparam int PW = (N_PLAYERS > 1) ? $clog2(N_PLAYERS) : 1
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [N_PLAYERS-1:0] button_activation,
  input  logic                 pronto_tx,
  output logic                 zera,
  output logic                 reg_jogada,
  output logic                 reg_comp,
  output logic                 partida_tx,
  output logic                 pronto_comparacao,
  output logic [CW-1:0]        char_idx,
  output logic [PW-1:0]        player_sel,
  output logic                 busy,
  output logic                 pronto,
  output logic                 erro_tx
);

  typedef enum logic [2:0] {
    INICIAL  = 3'd0,
    REGISTRA = 3'd1,
    COMPARA  = 3'd2,
    ENVIA    = 3'd3,
    AGUARDA  = 3'd4,
    PROXIMO  = 3'd5,
    PRONTO   = 3'd6,
    ERRO     = 3'd7
  } state_t;

  state_t               state;
  state_t               state_next;
  logic [N_PLAYERS-1:0] pending;
  logic [N_PLAYERS-1:0] req;
  logic [N_PLAYERS-1:0] grant_mask;
  logic [PW-1:0]        rr;
  logic [PW-1:0]        rr_next;
  logic [PW-1:0]        grant_idx;
  logic                 grant_valid;
  logic                 take;
  logic                 last_char;
  logic                 wdog_expired;

  assign last_char = (char_idx == CW'(MSG_LEN - 1));
  assign take      = (state == INICIAL) && grant_valid;

`ifdef TX_WATCHDOG_EN
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TW-1:0] wdog;

  // Watchdog: zero outside AGUARDA, so it starts at 0 on every entry.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)               wdog <= '0;
    else if (state == AGUARDA)  wdog <= wdog + TW'(1);
    else                        wdog <= '0;
  end

  assign wdog_expired = (wdog == TW'(TIMEOUT_CYCLES - 1));
`else
  assign wdog_expired = 1'b0;

  // The timeout only matters to the watchdog build; this block just anchors it.
  if (TIMEOUT_CYCLES < 1) begin : g_timeout_unused
  end
`endif

  // Round-robin search over pending plus same-cycle pulses, starting at rr.
  always_comb begin
    req         = pending | button_activation;
    grant_valid = 1'b0;
    grant_idx   = '0;
    grant_mask  = '0;
    rr_next     = rr;
    for (int k = 0; k < N_PLAYERS; k++) begin
      int idx;
      int nxt;
      idx = (int'(rr) + k) % N_PLAYERS;
      nxt = (idx + 1) % N_PLAYERS;
      if (!grant_valid && req[idx[PW-1:0]]) begin
        grant_valid                = 1'b1;
        grant_idx                  = idx[PW-1:0];
        grant_mask[idx[PW-1:0]]    = 1'b1;
        rr_next                    = nxt[PW-1:0];
      end
    end
  end

  // Next-state logic and Moore output decode.
  always_comb begin
    state_next        = state;
    zera              = 1'b0;
    reg_jogada        = 1'b0;
    reg_comp          = 1'b0;
    partida_tx        = 1'b0;
    pronto_comparacao = 1'b0;
    pronto            = 1'b0;
    erro_tx           = 1'b0;
    case (state)
      INICIAL: begin
        zera = 1'b1;
        if (grant_valid) state_next = REGISTRA;
      end
      REGISTRA: begin
        reg_jogada = 1'b1;
        state_next = COMPARA;
      end
      COMPARA: begin
        reg_comp   = 1'b1;
        state_next = ENVIA;
      end
      ENVIA: begin
        partida_tx        = 1'b1;
        pronto_comparacao = 1'b1;
        state_next        = AGUARDA;
      end
      AGUARDA: begin
        pronto_comparacao = 1'b1;
        // A completion on the terminal watchdog count still wins.
        if (pronto_tx)         state_next = last_char ? PRONTO : PROXIMO;
        else if (wdog_expired) state_next = ERRO;
      end
      PROXIMO: begin
        pronto_comparacao = 1'b1;
        state_next        = ENVIA;
      end
      PRONTO: begin
        pronto_comparacao = 1'b1;
        pronto            = 1'b1;
        state_next        = INICIAL;
      end
      ERRO: begin
`ifdef TX_WATCHDOG_EN
        erro_tx = 1'b1;
`endif
        state_next = INICIAL;
      end
      default: state_next = INICIAL;
    endcase
  end

  assign busy = (state != INICIAL);

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= INICIAL;
    else          state <= state_next;
  end

  // Pending requests, rr pointer, granted player and char index.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pending    <= '0;
      rr         <= '0;
      player_sel <= '0;
      char_idx   <= '0;
    end else begin
      // Grant clears its bit even if the same player pulses again this cycle.
      pending <= (pending | button_activation) & ~(take ? grant_mask : '0);
      if (take) begin
        player_sel <= grant_idx;
        rr         <= rr_next;
        char_idx   <= '0;
      end else if (state == PROXIMO) begin
        char_idx <= char_idx + CW'(1);
      end else if (state == PRONTO || state == ERRO) begin
        char_idx <= '0;
      end
    end
  end

endmodule
